// File: rtl/lisnoc_router_input_port_pkg.sv
// Shared definitions for the lisnoc router input port.
// Holds the flit type codes, the per-VC route FSM states and a small
// classification helper used by the route logic.
package lisnoc_router_input_port_pkg;

  // Width of the flit type field that the type codes below are encoded in
  localparam int unsigned flit_type_code_width = 2;

  // Flit type codes, carried in the top bits of every flit
  typedef enum logic [flit_type_code_width-1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEADER  = 2'b01,
    FLIT_LAST    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_e;

  // Per-VC routing state
  typedef enum logic [1:0] {
    ROUTE_IDLE   = 2'b00,
    ROUTE_ACTIVE = 2'b01,
    ROUTE_DROP   = 2'b10
  } route_state_e;

  // True for flit types that carry a destination field
  function automatic logic is_head_type(input logic [flit_type_code_width-1:0] t);
    return (t == FLIT_HEADER) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/lisnoc_fifo.sv
// Synchronous flit FIFO with registered full/empty views.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_flit/in_valid    write side; a flit is taken when in_valid && in_ready
//   in_ready            not full (registered)
//   out_flit/out_valid  head of the FIFO; out_valid = not empty (registered)
//   out_ready           pop the head this cycle
module lisnoc_fifo #(
  parameter int unsigned flit_width = 34,
  parameter int unsigned length     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [flit_width-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [flit_width-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned ptr_width = (length > 1) ? $clog2(length) : 1;
  localparam int unsigned cnt_width = $clog2(length + 1);

  logic [flit_width-1:0] mem [length];
  logic [ptr_width-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0]  rd_ptr_q, rd_ptr_d;
  logic [cnt_width-1:0]  count_q, count_d;
  logic                  push_c, pop_c;

  // Wrapping pointer increment that also handles non power-of-two depths
  function automatic logic [ptr_width-1:0] ptr_next(input logic [ptr_width-1:0] p);
    return (p == ptr_width'(length - 1)) ? '0 : p + ptr_width'(1);
  endfunction

  // Next-state for pointers and occupancy
  always_comb begin
    push_c   = in_valid & in_ready;
    pop_c    = out_ready & out_valid;
    wr_ptr_d = push_c ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_c ? ptr_next(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + cnt_width'(1);
      2'b01:   count_d = count_q - cnt_width'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; full and empty are kept as flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      in_ready  <= (count_d != cnt_width'(length));
      out_valid <= (count_d != '0);
    end
  end

  // Storage needs no reset: out_valid masks stale contents
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= in_flit;
    end
  end

  assign out_flit = mem[rd_ptr_q];

endmodule

// File: rtl/lisnoc_router_input_route.sv
// Route FSM, destination lookup and one-entry output register for one VC.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_flit, in_valid   FIFO head and its valid
//   pop_c               pop the FIFO head this cycle (combinational)
//   read                switch read strobes, one per output port
//   request             one-hot output port request (zero when empty)
//   out_flit            flit held in the output register
module lisnoc_router_input_route
  import lisnoc_router_input_port_pkg::*;
#(
  parameter int unsigned flit_data_width = 32,
  parameter int unsigned flit_type_width = 2,
  parameter int unsigned ph_dest_width   = 5,
  parameter int unsigned num_dests       = 32,
  parameter int unsigned ports           = 5,
  parameter logic [num_dests*ports-1:0] lookup = '0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [flit_data_width+flit_type_width-1:0] in_flit,
  input  logic                                       in_valid,
  output logic                                       pop_c,
  input  logic [ports-1:0]                           read,
  output logic [ports-1:0]                           request,
  output logic [flit_data_width+flit_type_width-1:0] out_flit
);

  localparam int unsigned flit_width = flit_data_width + flit_type_width;

  route_state_e                 state_q, state_d;
  logic [ports-1:0]             route_q, route_d;
  logic [ports-1:0]             request_d;
  logic [flit_width-1:0]        flit_d;
  logic [flit_type_code_width-1:0] head_type;
  logic [ph_dest_width-1:0]     dest;
  logic [ports-1:0]             entry;
  logic [ports-1:0]             sel;
  logic                         keep;
  logic                         read_c;
  logic                         oreg_valid;

  assign head_type = in_flit[flit_width-1 -: flit_type_code_width];
  assign dest      = in_flit[flit_data_width-1 -: ph_dest_width];

  // Lookup, FSM next state, pop decision and output register next value
  always_comb begin
    entry     = '0;
    keep      = 1'b0;
    sel       = '0;
    state_d   = state_q;
    route_d   = route_q;
    request_d = request;
    flit_d    = out_flit;

    // Out-of-range destinations leave entry at zero, i.e. unroutable
    for (int unsigned d = 0; d < num_dests; d++) begin
      if (32'(dest) == d) begin
        entry = lookup[d*ports +: ports];
      end
    end

    // A loaded request is always nonzero, so it doubles as the valid bit
    oreg_valid = |request;
    // Reads on ports other than the selected one are ignored
    read_c     = |(read & request);

    // Header/single flits restart routing from any state
    if (is_head_type(head_type)) begin
      keep = (entry != '0);
      sel  = entry;
      if (head_type == FLIT_HEADER) begin
        state_d = keep ? ROUTE_ACTIVE : ROUTE_DROP;
        if (keep) begin
          route_d = entry;
        end
      end else begin
        state_d = ROUTE_IDLE;
      end
    end else begin
      case (state_q)
        ROUTE_ACTIVE: begin
          keep = 1'b1;
          sel  = route_q;
          if (head_type == FLIT_LAST) begin
            state_d = ROUTE_IDLE;
          end
        end
        ROUTE_DROP: begin
          if (head_type == FLIT_LAST) begin
            state_d = ROUTE_IDLE;
          end
        end
        default: begin
          // Orphan payload/last in IDLE is discarded
        end
      endcase
    end

    // Discarded flits never wait for output register space
    pop_c = in_valid & (~keep | ~oreg_valid | read_c);

    if (!pop_c) begin
      state_d = state_q;
      route_d = route_q;
    end

    if (read_c) begin
      request_d = '0;
    end
    if (pop_c && keep) begin
      request_d = sel;
      flit_d    = in_flit;
    end
  end

  // FSM, route and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ROUTE_IDLE;
      route_q  <= '0;
      request  <= '0;
      out_flit <= '0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      request  <= request_d;
      out_flit <= flit_d;
    end
  end

endmodule

// File: rtl/lisnoc_router_input_port.sv
// Receive-side port of a lisnoc router.
// Buffers each virtual channel in its own FIFO, routes packets through a
// destination lookup table and presents one flit plus a one-hot output
// request per VC to the switch.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   link_flit       incoming flit, shared by all VCs
//   link_valid      per-VC flit valid (at most one bit set)
//   link_ready      per-VC FIFO not full
//   switch_request  bit v*ports+p: VC v requests output p
//   switch_flit     VC v flit at [(v+1)*flit_width-1 : v*flit_width]
//   switch_read     bit v*ports+p: output p takes VC v's flit this cycle
module lisnoc_router_input_port
  import lisnoc_router_input_port_pkg::*;
#(
  parameter int unsigned flit_data_width = 32,
  parameter int unsigned flit_type_width = 2,
  parameter int unsigned ph_dest_width   = 5,
  parameter int unsigned num_dests       = 32,
  parameter int unsigned ports           = 5,
  parameter logic [num_dests*ports-1:0] lookup = '0,
  parameter int unsigned vchannels       = 1,
  parameter int unsigned fifo_length     = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [flit_data_width+flit_type_width-1:0]           link_flit,
  input  logic [vchannels-1:0]                                 link_valid,
  output logic [vchannels-1:0]                                 link_ready,
  output logic [ports*vchannels-1:0]                           switch_request,
  output logic [(flit_data_width+flit_type_width)*vchannels-1:0] switch_flit,
  input  logic [ports*vchannels-1:0]                           switch_read
);

  localparam int unsigned flit_width = flit_data_width + flit_type_width;

  // One independent FIFO + route stage per virtual channel
  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    logic [flit_width-1:0] fifo_flit;
    logic                  fifo_valid;
    logic                  fifo_pop_c;

    lisnoc_fifo #(
      .flit_width (flit_width),
      .length     (fifo_length)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (link_flit),
      .in_valid  (link_valid[v]),
      .in_ready  (link_ready[v]),
      .out_flit  (fifo_flit),
      .out_valid (fifo_valid),
      .out_ready (fifo_pop_c)
    );

    lisnoc_router_input_route #(
      .flit_data_width (flit_data_width),
      .flit_type_width (flit_type_width),
      .ph_dest_width   (ph_dest_width),
      .num_dests       (num_dests),
      .ports           (ports),
      .lookup          (lookup)
    ) u_route (
      .clk      (clk),
      .rst      (rst),
      .in_flit  (fifo_flit),
      .in_valid (fifo_valid),
      .pop_c    (fifo_pop_c),
      .read     (switch_read[v*ports +: ports]),
      .request  (switch_request[v*ports +: ports]),
      .out_flit (switch_flit[v*flit_width +: flit_width])
    );
  end

endmodule

// File: tb/tb_lisnoc_router_input_port.sv
// Directed bench for lisnoc_router_input_port with a per-VC scoreboard.
module tb_lisnoc_router_input_port;

  localparam int unsigned NP  = 5;
  localparam int unsigned NVC = 2;
  localparam int unsigned FW  = 34;

  localparam logic [5:0] P = 0;
  localparam logic [1:0] T_PAY = 2'b00, T_HDR = 2'b01, T_LAST = 2'b10, T_SGL = 2'b11;

  // dest1 -> port1, dest2 -> port3, dest4 -> port0, dest5 -> port4, others unroutable
  localparam logic [159:0] LOOKUP = (160'(5'b00010) << 5)  | (160'(5'b01000) << 10) |
                                    (160'(5'b00001) << 20) | (160'(5'b10000) << 25);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [FW-1:0]         link_flit = '0;
  logic [NVC-1:0]        link_valid = '0;
  logic [NVC-1:0]        link_ready;
  logic [NP*NVC-1:0]     switch_request;
  logic [FW*NVC-1:0]     switch_flit;
  logic [NP*NVC-1:0]     switch_read;
  logic [NVC-1:0]        read_en = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hits = 0, hit_first = 0, hit_last = 0;
  int any_req = 0;
  logic [NP-1:0] watch = 5'b11111;

  logic [NP+FW-1:0] sb [NVC][$];

  always #5 clk = ~clk;

  // Switch model: reads only the port that is being requested
  assign switch_read = {{NP{read_en[1]}} & switch_request[2*NP-1:NP],
                        {NP{read_en[0]}} & switch_request[NP-1:0]};

  lisnoc_router_input_port #(
    .flit_data_width (32),
    .flit_type_width (2),
    .ph_dest_width   (5),
    .num_dests       (32),
    .ports           (NP),
    .lookup          (LOOKUP),
    .vchannels       (NVC),
    .fifo_length     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .link_flit      (link_flit),
    .link_valid     (link_valid),
    .link_ready     (link_ready),
    .switch_request (switch_request),
    .switch_flit    (switch_flit),
    .switch_read    (switch_read)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [4:0] d, input int tg);
    return {t, d, 27'(tg)};
  endfunction

  // Monitor: every read the switch performs is compared against the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (switch_request[NP-1:0] == watch) begin
        hits++;
        if (hits == 1) hit_first = cyc;
        hit_last = cyc;
      end
      if (switch_request != '0) any_req++;
      for (int v = 0; v < NVC; v++) begin
        logic [NP-1:0]    req;
        logic [NP+FW-1:0] e;
        req = switch_request[v*NP +: NP];
        if (read_en[v] && req != '0) begin
          if (sb[v].size() == 0) begin
            check($sformatf("vc%0d_unexpected_req", v), 64'(req), 64'(0));
          end else begin
            e = sb[v].pop_front();
            check($sformatf("vc%0d_out", v), 64'({req, switch_flit[v*FW +: FW]}), 64'(e));
          end
        end
      end
    end
  end

  // Drive one flit on VC v; exp_req = 0 means the port must discard it
  task automatic send(input int v, input logic [1:0] t, input logic [4:0] d,
                      input int tg, input logic [NP-1:0] exp_req);
    logic [FW-1:0] f;
    f = mk(t, d, tg);
    @(negedge clk);
    link_flit     = f;
    link_valid    = '0;
    link_valid[v] = 1'b1;
    for (int i = 0; i < 64 && !link_ready[v]; i++) @(negedge clk);
    check("link_ready", 64'(link_ready[v]), 64'(1));
    if (exp_req != '0) sb[v].push_back({exp_req, f});
    @(posedge clk);
    #1 link_valid = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (sb[0].size() == 0 && sb[1].size() == 0 && switch_request == '0) break;
    end
    check("drain", 64'(sb[0].size() + sb[1].size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic rdy;
    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_request", 64'(switch_request), 64'(0));
    check("rst_ready", 64'(link_ready), 64'(2'b11));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: single flit latency and read
    send(0, T_SGL, 5'd2, 27'h11, 5'b01000);
    check("t1_cycle1_req", 64'(switch_request), 64'(0));
    @(posedge clk); #1;
    check("t1_cycle2_req", 64'(switch_request), 64'(5'b01000));
    read_en[0] = 1'b1;
    @(posedge clk); #1;
    read_en[0] = 1'b0;
    check("t1_cycle3_req", 64'(switch_request), 64'(0));

    // 2: back-to-back packet with read held, then a packet to another port
    read_en = 2'b11;
    hits = 0;
    watch = 5'b01000;
    send(0, T_HDR,  5'd2, 27'h21, 5'b01000);
    send(0, T_PAY,  5'd9, 27'h22, 5'b01000);
    send(0, T_PAY,  5'd3, 27'h23, 5'b01000);
    send(0, T_LAST, 5'd0, 27'h24, 5'b01000);
    send(0, T_HDR,  5'd4, 27'h25, 5'b00001);
    send(0, T_LAST, 5'd7, 27'h26, 5'b00001);
    drain();
    watch = 5'b11111;
    check("t2_req_cycles", 64'(hits), 64'(4));
    check("t2_req_consecutive", 64'(hit_last - hit_first), 64'(3));

    // 3: backpressure, capacity fifo_length+1
    read_en = 2'b00;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      link_flit     = mk((i == 0) ? T_HDR : T_PAY, 5'd1, 27'h30 + i);
      link_valid    = 2'b01;
      rdy           = link_ready[0];
      check($sformatf("t3_ready_%0d", i), 64'(rdy), 64'(i < 5));
      if (rdy) sb[0].push_back({5'b00010, link_flit});
      @(posedge clk);
      #1 link_valid = '0;
    end
    check("t3_ready_full", 64'(link_ready[0]), 64'(0));
    read_en[0] = 1'b1;
    @(posedge clk); #1;
    read_en[0] = 1'b0;
    check("t3_ready_after_read", 64'(link_ready[0]), 64'(1));
    read_en = 2'b11;
    send(0, T_PAY,  5'd0, 27'h3a, 5'b00010);
    send(0, T_LAST, 5'd0, 27'h3b, 5'b00010);
    drain();

    // 4: two VCs interleaved
    send(0, T_HDR,  5'd1, 27'h41, 5'b00010);
    send(1, T_HDR,  5'd5, 27'h51, 5'b10000);
    send(0, T_PAY,  5'd5, 27'h42, 5'b00010);
    send(1, T_PAY,  5'd1, 27'h52, 5'b10000);
    send(0, T_LAST, 5'd0, 27'h43, 5'b00010);
    send(1, T_LAST, 5'd0, 27'h53, 5'b10000);
    drain();

    // 5: orphan and unroutable flits are dropped
    any_req = 0;
    send(0, T_PAY,  5'd2,  27'h61, '0);
    send(0, T_HDR,  5'd31, 27'h62, '0);
    send(0, T_PAY,  5'd2,  27'h63, '0);
    send(0, T_PAY,  5'd2,  27'h64, '0);
    send(0, T_LAST, 5'd2,  27'h65, '0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_request", 64'(any_req), 64'(0));
    send(0, T_SGL, 5'd2, 27'h66, 5'b01000);
    drain();

    // 6: reset mid-packet
    send(0, T_HDR, 5'd2, 27'h71, 5'b01000);
    send(0, T_PAY, 5'd2, 27'h72, 5'b01000);
    check("t6_req_before_rst", 64'(switch_request), 64'(5'b01000));
    rst = 1'b1;
    #1;
    check("t6_req_async_rst", 64'(switch_request), 64'(0));
    check("t6_ready_rst", 64'(link_ready), 64'(2'b11));
    sb[0].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(0, T_PAY,  5'd2, 27'h73, '0);
    send(0, T_LAST, 5'd2, 27'h74, '0);
    send(0, T_HDR,  5'd2, 27'h75, 5'b01000);
    send(0, T_LAST, 5'd0, 27'h76, 5'b01000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
